// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default sizing for timer_shift_count
package timer_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;
    localparam int DELAY_W_DEF         = 4;
    localparam int CYCLES_PER_UNIT_DEF = 1000;
endpackage

// File: rtl/timer_shift_count_unit_prescaler.sv
// unit_prescaler: mod-CYCLES_PER_UNIT counter with a one-cycle tick at terminal count
module unit_prescaler #(
    parameter int CYCLES_PER_UNIT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CNT_W = $clog2(CYCLES_PER_UNIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_UNIT - 1);
    logic [CNT_W-1:0] r_cnt;
    assign tick = enable && r_cnt == LAST;
    always_ff @(posedge clk) begin
        if (reset || clear) r_cnt <= '0;
        else if (enable) r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
    end
endmodule

// File: rtl/timer_shift_count.sv
// timer_shift_count: shifts in a delay MSB-first, times (delay+1) units, then holds done until ack.
// Optional TIMER_SHIFT_COUNT_ABORT_EN adds an abort input that cancels SHIFT/COUNT.
module timer_shift_count
    import timer_pkg::*;
#(
    parameter int DELAY_W         = DELAY_W_DEF,
    parameter int CYCLES_PER_UNIT = CYCLES_PER_UNIT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_shifting,
    input  logic               data,
    input  logic               ack,
`ifdef TIMER_SHIFT_COUNT_ABORT_EN
    input  logic               abort,
`endif
    output logic               counting,
    output logic               done,
    output logic [DELAY_W-1:0] remaining
);
    localparam int BIT_W = $clog2(DELAY_W) + 1;
    state_t             r_state, w_next;
    logic [DELAY_W-2:0] r_shift;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [DELAY_W-1:0] r_remaining, w_shift;
    logic               w_tick, w_abort, w_last_bit, w_shift_en;
`ifdef TIMER_SHIFT_COUNT_ABORT_EN
    assign w_abort = abort && (r_state == SHIFT || r_state == COUNT);
`else
    assign w_abort = 1'b0;
`endif
    // only the low bits are kept: the bit shifted out the top is never needed
    assign w_shift    = {r_shift, data};
    assign w_last_bit = r_state == SHIFT && r_bit_cnt == BIT_W'(DELAY_W - 1);
    assign w_shift_en = (r_state == IDLE && start_shifting) || r_state == SHIFT;
    unit_prescaler #(.CYCLES_PER_UNIT(CYCLES_PER_UNIT)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (r_state != COUNT || w_abort),
        .enable (r_state == COUNT),
        .tick   (w_tick)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  w_next = start_shifting ? SHIFT : IDLE;
            SHIFT: w_next = w_last_bit ? COUNT : SHIFT;
            COUNT: w_next = (w_tick && r_remaining == '0) ? DONE : COUNT;
            DONE:  w_next = ack ? IDLE : DONE;
        endcase
        if (w_abort) w_next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_remaining <= '0;
        end else begin
            r_state <= w_next;
            if (w_shift_en) begin
                r_shift   <= w_shift[DELAY_W-2:0];
                r_bit_cnt <= r_state == IDLE ? BIT_W'(1) : r_bit_cnt + BIT_W'(1);
            end
            if (w_abort) r_remaining <= '0;
            else if (w_last_bit) r_remaining <= w_shift;
            else if (r_state == COUNT && w_tick && r_remaining != '0) r_remaining <= r_remaining - DELAY_W'(1);
        end
    end
    assign counting  = r_state == COUNT;
    assign done      = r_state == DONE;
    assign remaining = r_remaining;
endmodule

// File: tb/tb_timer_shift_count.sv
// tb_timer_shift_count: directed vectors with hand-computed expectations, CYCLES_PER_UNIT=4, DELAY_W=4.
// Build with TIMER_SHIFT_COUNT_ABORT_EN defined to exercise abort; otherwise the port is left out.
module tb_timer_shift_count;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_shifting = 1'b0;
    logic       data = 1'b0;
    logic       ack = 1'b0;
`ifdef TIMER_SHIFT_COUNT_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       counting, done;
    logic [3:0] remaining;
    int         n_vec = 0;
    int         n_err = 0;
    int         n;
    always #5 clk = ~clk;
    timer_shift_count #(.DELAY_W(4), .CYCLES_PER_UNIT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_shifting (start_shifting),
        .data           (data),
        .ack            (ack),
`ifdef TIMER_SHIFT_COUNT_ABORT_EN
        .abort          (abort),
`endif
        .counting       (counting),
        .done           (done),
        .remaining      (remaining)
    );
    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic shift_in(input logic [3:0] v);
        start_shifting = 1'b1;
        data = v[3];
        step();
        start_shifting = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            data = v[i];
            step();
        end
    endtask
    // counts cycles spent in COUNT; optionally checks the per-unit remaining steps
    task automatic run_count(input int d, input bit steps, input bit pulse, output int cnt);
        cnt = 0;
        while (counting && cnt < 200) begin
            if (steps && cnt % 4 == 0) chk("rem_step", remaining, d - cnt / 4);
            start_shifting = pulse && cnt == 0;
            data = 1'b1;
            cnt++;
            step();
        end
        start_shifting = 1'b0;
    endtask
    task automatic ack_pulse();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask
    initial begin
        step();
        step();
        chk("rst_counting", counting, 0);
        chk("rst_done", done, 0);
        chk("rst_remaining", remaining, 0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            data = i[0];
            step();
        end
        chk("idle_no_start", counting, 0);
        shift_in(4'b0101);
        chk("load_0101", remaining, 5);
        chk("count_0101", counting, 1);
        run_count(5, 1'b1, 1'b0, n);
        chk("len_0101", n, 24);
        chk("done_0101", done, 1);
        chk("rem_end_0101", remaining, 0);
        ack_pulse();
        chk("ack_0101", done, 0);
        shift_in(4'b0000);
        run_count(0, 1'b0, 1'b0, n);
        chk("len_0000", n, 4);
        for (int i = 0; i < 10; i++) step();
        chk("done_hold", done, 1);
        ack_pulse();
        chk("ack_0000", done, 0);
        shift_in(4'b1111);
        chk("load_1111", remaining, 15);
        run_count(15, 1'b1, 1'b0, n);
        chk("len_1111", n, 64);
        ack_pulse();
        start_shifting = 1'b1;
        data = 1'b0;
        step();
        start_shifting = 1'b1;
        step();
        start_shifting = 1'b0;
        data = 1'b1;
        step();
        step();
        chk("load_ign", remaining, 3);
        run_count(3, 1'b0, 1'b1, n);
        chk("len_ign", n, 16);
        start_shifting = 1'b1;
        step();
        chk("done_ign", done, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        start_shifting = 1'b0;
        chk("ack_with_start", done, 0);
        for (int i = 0; i < 5; i++) step();
        chk("idle_after_ack", counting, 0);
        start_shifting = 1'b1;
        data = 1'b1;
        step();
        start_shifting = 1'b0;
        data = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_shift_counting", counting, 0);
        for (int i = 0; i < 4; i++) step();
        chk("rst_shift_idle", counting, 0);
        shift_in(4'b0011);
        step();
        step();
        chk("pre_rst_rem", remaining, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_cnt_counting", counting, 0);
        chk("rst_cnt_done", done, 0);
        chk("rst_cnt_rem", remaining, 0);
        shift_in(4'b0010);
        run_count(2, 1'b1, 1'b0, n);
        chk("len_0010", n, 12);
        ack_pulse();
`ifdef TIMER_SHIFT_COUNT_ABORT_EN
        shift_in(4'b0010);
        for (int i = 0; i < 5; i++) step();
        chk("pre_abort_rem", remaining, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_counting", counting, 0);
        chk("abort_rem", remaining, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            n += int'(done);
            step();
        end
        chk("abort_no_done", n, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/timer_shift_count.md
Name: timer_shift_count

Overview:
- Downstream stage of the serial pattern detector. It consumes the detector's one-cycle `start_shifting` pulse and the same serial `data` stream.
- Shifts in a DELAY_W-bit delay value, MSB first, then runs a timer of (delay+1)*CYCLES_PER_UNIT cycles.
- Then raises `done` and waits for `ack` before re-arming.

Parameters:
- DELAY_W, 4: width of the delay field shifted in from `data`.
- CYCLES_PER_UNIT, 1000: clock cycles per delay unit. Must be at least 2. Tests override it to 4.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start_shifting  in  1  one-cycle pulse from the detector; `data` in the same cycle is the delay MSB.
- data  in  1  serial bit stream shared with the detector.
- ack  in  1  consumer acknowledge of `done`.
- counting  out  1  high while the timer runs.
- done  out  1  high from timer expiry until `ack` is taken.
- remaining  out  DELAY_W  current delay-unit count.

Behaviour:
- FSM states: IDLE, SHIFT, COUNT, DONE. Reset forces IDLE with shift_reg=0, bit_cnt=0, unit_cnt=0, remaining=0. Outputs after reset: counting=0, done=0, remaining=0.
- Reset takes effect on the next edge from any state, including mid-shift and mid-count.
- IDLE:
  - On an edge with start_shifting=1: shift_reg <= {shift_reg[DELAY_W-2:0], data}, bit_cnt <= 1, go to SHIFT.
  - Otherwise stay in IDLE; data is ignored.
- SHIFT:
  - Each edge shifts `data` into the LSB and increments bit_cnt.
  - On the edge that captures bit DELAY_W (bit_cnt==DELAY_W-1 before the edge): remaining <= the full DELAY_W-bit value, unit_cnt <= 0, go to COUNT.
  - The SHIFT period is therefore DELAY_W consecutive data bits, with the first bit sampled in IDLE.
  - start_shifting is ignored in SHIFT.
- COUNT:
  - unit_cnt increments every cycle.
  - When unit_cnt==CYCLES_PER_UNIT-1: unit_cnt <= 0. Then:
    - if remaining==0, go to DONE;
    - otherwise remaining decrements by 1.
  - COUNT lasts exactly (D+1)*CYCLES_PER_UNIT cycles for loaded value D. D=0 gives CYCLES_PER_UNIT cycles.
  - remaining never wraps below 0.
- DONE:
  - Hold until an edge with ack=1, then go to IDLE.
  - ack outside DONE has no effect.
  - start_shifting is ignored in DONE, even if it coincides with ack. The next pulse must arrive in IDLE.
- Outputs are Moore and decoded from the registered state, with no combinational path from inputs:
  - counting = (state==COUNT)
  - done = (state==DONE)
  - remaining = the register, held in DONE and IDLE until the next load.
- Width rules: unit_cnt is $clog2(CYCLES_PER_UNIT) bits; bit_cnt is $clog2(DELAY_W)+1 bits.

Optional Feature:
- Macro: TIMER_SHIFT_COUNT_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit, after `ack`).
  - abort=1 on an edge in SHIFT or COUNT forces IDLE with remaining=0 and unit_cnt=0.
  - abort in IDLE or DONE has no effect.
  - If reset and abort are both high, reset wins; the result is identical.
- Undefined: no `abort` port and no abort logic.

Decomposition:
- Package timer_pkg holds:
  - the state enum typedef (IDLE=2'd0, SHIFT=2'd1, COUNT=2'd2, DONE=2'd3);
  - default constants DELAY_W_DEF=4 and CYCLES_PER_UNIT_DEF=1000.
- One sub-module, unit_prescaler: mod-CYCLES_PER_UNIT counter.
  - Inputs: clk, reset, clear, enable. Output: one-cycle `tick` at the terminal count.
  - The FSM clears it on entry to COUNT and uses `tick` to decrement or finish.

Test Plan (CYCLES_PER_UNIT=4, DELAY_W=4):
- Reset behaviour: assert reset 2 cycles -> counting=0, done=0, remaining=0. Toggle data with no start_shifting -> state stays IDLE.
- Delay 0101: start_shifting pulse with data=0, then data 1,0,1 -> remaining=5 and counting=1 for exactly 24 cycles, then done=1. remaining steps 5,4,3,2,1,0 every 4 cycles.
- Delay 0000 and delay 1111: counting lasts 4 cycles and 64 cycles respectively. done is held 10 cycles without ack; ack=1 for one cycle -> done=0 on the following edge.
- Ignored pulses: pulse start_shifting during SHIFT, COUNT and DONE (including the same cycle as ack) -> no restart; counting duration unchanged; IDLE is re-entered after ack.
- Reset mid-operation: reset during SHIFT (after 2 bits) and during COUNT (remaining=3) -> IDLE next edge, all outputs 0. A fresh shift of 0010 then gives 12 counting cycles.
- Abort (TIMER_SHIFT_COUNT_ABORT_EN defined): abort in COUNT -> IDLE, remaining=0, done never asserts. Without the macro, the bench confirms the port is absent.
